// File: rtl/shared_reg_write_arbiter.sv
// shared_reg_write_arbiter
//   Single owner of a shared data register that two writers (A, B) would
//   otherwise both update on one clock edge. Each posedge picks at most one
//   winner using round-robin priority, then registers that writer's data into
//   data_out. Cycles in which both eligible writers request are counted in a
//   saturating debug counter.
//
//   state  | meaning
//   PRIO_A | A wins the next simultaneous request
//   PRIO_B | B wins the next simultaneous request
//
// Ports
//   clk            clock, all state updates on posedge
//   rst            asynchronous active-high reset
//   req_a, data_a  writer A request (held until gnt_a) and its data
//   req_b, data_b  writer B request (held until gnt_b) and its data
//   gnt_a, gnt_b   registered one-cycle grant pulses, never both high
//   data_out       shared register value
//   data_valid     one-cycle pulse when data_out was written
//   last_winner    0 = A, 1 = B, winner of the most recent write
//   collision_cnt  saturating count of cycles with both writers eligible
module shared_reg_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              last_winner,
  output logic [CNT_W-1:0]  collision_cnt
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t state_q, state_d;
  logic  elig_a, elig_b;
  logic  win_a, win_b;
  logic  collide;

  // A writer whose grant is showing this cycle has not had a chance to drop
  // req yet, so it is masked to avoid a duplicate write of the same data.
  assign elig_a = req_a & ~gnt_a;
  assign elig_b = req_b & ~gnt_b;

  always_comb begin
    state_d = state_q;
    win_a   = 1'b0;
    win_b   = 1'b0;
    collide = 1'b0;
    if (elig_a && elig_b) begin
      collide = 1'b1;
      if (state_q == PRIO_A) begin
        win_a   = 1'b1;
        state_d = PRIO_B;
      end else begin
        win_b   = 1'b1;
        state_d = PRIO_A;
      end
    end else if (elig_a) begin
      win_a   = 1'b1;
      state_d = PRIO_B;
    end else if (elig_b) begin
      win_b   = 1'b1;
      state_d = PRIO_A;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= PRIO_A;
      gnt_a         <= 1'b0;
      gnt_b         <= 1'b0;
      data_valid    <= 1'b0;
      data_out      <= '0;
      last_winner   <= 1'b0;
      collision_cnt <= '0;
    end else begin
      state_q    <= state_d;
      gnt_a      <= win_a;
      gnt_b      <= win_b;
      data_valid <= win_a | win_b;
      if (win_a) begin
        data_out    <= data_a;
        last_winner <= 1'b0;
      end else if (win_b) begin
        data_out    <= data_b;
        last_winner <= 1'b1;
      end
      if (collide && (collision_cnt != {CNT_W{1'b1}}))
        collision_cnt <= collision_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
